// File: rtl/dpot_sweep.sv
// Wiper code sequencer for the Pmod DPOT SPI interface: hold / saw up / saw down / triangle.
// Optional handshake watchdog enabled by defining DPOT_SWEEP_TIMEOUT_EN.
module dpot_sweep #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned TICK_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] step,
  input  logic [7:0] hold_val,
  input  logic       ready,
  output logic [7:0] value,
  output logic       update,
  output logic       busy,
  output logic       wrap,
  output logic       error
);

  localparam int unsigned CODE_W = 8;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic                dir_down_q, dir_down_d;
  logic [CODE_W-1:0]   value_d;
  logic                update_d, busy_d, wrap_d;
  logic                err_hold;

  // Next-code datapath
  logic [CODE_W:0]     sum_c, diff_c;
  logic [CODE_W-1:0]   nxt_val_c;
  logic                nxt_dir_down_c, nxt_wrap_c;

  always_comb begin
    sum_c          = {1'b0, value} + {1'b0, step};
    diff_c         = {1'b0, value} - {1'b0, step};
    nxt_val_c      = value;
    nxt_dir_down_c = dir_down_q;
    nxt_wrap_c     = 1'b0;
    case (mode)
      2'd0: nxt_val_c = hold_val;
      2'd1: begin
        nxt_val_c  = sum_c[CODE_W-1:0];
        nxt_wrap_c = sum_c[CODE_W];
      end
      2'd2: begin
        nxt_val_c  = diff_c[CODE_W-1:0];
        nxt_wrap_c = diff_c[CODE_W];
      end
      default: begin
        if (!dir_down_q) begin
          if (sum_c[CODE_W]) begin
            nxt_val_c      = {CODE_W{1'b1}};
            nxt_dir_down_c = 1'b1;
            nxt_wrap_c     = 1'b1;
          end else begin
            nxt_val_c = sum_c[CODE_W-1:0];
          end
        end else begin
          if (diff_c[CODE_W]) begin
            nxt_val_c      = '0;
            nxt_dir_down_c = 1'b0;
            nxt_wrap_c     = 1'b1;
          end else begin
            nxt_val_c = diff_c[CODE_W-1:0];
          end
        end
      end
    endcase
  end

`ifdef DPOT_SWEEP_TIMEOUT_EN
  localparam int unsigned WD_W = 10;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(1022);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  assign err_hold = error_q;
  assign error    = error_q;
`else
  assign err_hold = 1'b0;
  assign error    = 1'b0;
`endif

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    value_d    = value;
    wrap_d     = 1'b0;
`ifdef DPOT_SWEEP_TIMEOUT_EN
    error_d    = error_q;
    wd_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && !err_hold) begin
          value_d    = hold_val;
          dir_down_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // A low ready is taken as acceptance, even if it was already low on entry.
        if (!ready) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (cnt_q == TICK_LAST) begin
          if (enable) begin
            value_d    = nxt_val_c;
            dir_down_d = nxt_dir_down_c;
            wrap_d     = nxt_wrap_c;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end
    endcase
`ifdef DPOT_SWEEP_TIMEOUT_EN
    // Watchdog counts consecutive cycles spent stalled in REQ or XFER.
    if ((state_q == ST_REQ || state_q == ST_XFER) && state_d == state_q) begin
      if (wd_q == WD_LAST) begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
    update_d = (state_d == ST_REQ);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      value      <= '0;
      update     <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
`ifdef DPOT_SWEEP_TIMEOUT_EN
      wd_q       <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      value      <= value_d;
      update     <= update_d;
      busy       <= busy_d;
      wrap       <= wrap_d;
`ifdef DPOT_SWEEP_TIMEOUT_EN
      wd_q       <= wd_d;
      error_q    <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_dpot_sweep.sv
// Self-checking bench for dpot_sweep: directed sweeps, random sweeps against a code model,
// enable-drop, async reset and stuck-ready behaviour.
module tb_dpot_sweep;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned TICK_W   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] step;
  logic [7:0] hold_val;
  logic       ready;
  logic [7:0] value;
  logic       update, busy, wrap, error;

  dpot_sweep #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .step(step),
    .hold_val(hold_val), .ready(ready), .value(value), .update(update),
    .busy(busy), .wrap(wrap), .error(error)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] cap_code[$];
  logic       cap_wrap[$];
  int         exp_code[$];
  int         exp_wrap[$];
  bit         rsp_on = 1'b1;
  logic       upd_prev = 1'b0;
  logic       rdy_prev = 1'b1;
  int         early_drop = 0;
  int         stray_wrap = 0;

  // DPOT-side responder: drops ready 2 cycles after a request, raises it 8 cycles later.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_on && update && ready) begin
        repeat (2) @(posedge clk);
        #1 ready = 1'b0;
        repeat (8) @(posedge clk);
        #1 ready = 1'b1;
      end
    end
  end

  // Record each new request, and watch for handshake/wrap protocol violations.
  always @(negedge clk) begin
    if (!rst) begin
      upd_prev = 1'b0;
      rdy_prev = ready;
    end else begin
      if (update && !upd_prev) begin
        cap_code.push_back(value);
        cap_wrap.push_back(wrap);
      end else if (wrap) begin
        stray_wrap++;
      end
      if (upd_prev && !update && !error && rdy_prev !== 1'b0) early_drop++;
      upd_prev = update;
      rdy_prev = ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: next wiper code computed directly from the sweep rules with integers.
  task automatic model(input int hv, input int st, input int md, input int n);
    int v, t, w;
    bit up;
    exp_code.delete();
    exp_wrap.delete();
    v  = hv;
    up = 1'b1;
    exp_code.push_back(v);
    exp_wrap.push_back(0);
    for (int i = 1; i < n; i++) begin
      w = 0;
      case (md)
        0: v = hv;
        1: begin t = v + st; w = (t > 255) ? 1 : 0; v = t % 256; end
        2: begin t = v - st; w = (t < 0) ? 1 : 0; v = (t + 256) % 256; end
        default: begin
          if (up) begin
            if (v + st > 255) begin v = 255; up = 1'b0; w = 1; end
            else v = v + st;
          end else begin
            if (v < st) begin v = 0; up = 1'b1; w = 1; end
            else v = v - st;
          end
        end
      endcase
      exp_code.push_back(v);
      exp_wrap.push_back(w);
    end
  endtask

  task automatic wait_caps(input string tag, input int n);
    int k = 0;
    while (cap_code.size() < n && k < 60 * n) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_count_reached"}, 32'(cap_code.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    logic [31:0] oc, ow;
    for (int i = 0; i < exp_code.size(); i++) begin
      oc = (i < cap_code.size()) ? 32'(cap_code[i]) : 'x;
      ow = (i < cap_wrap.size()) ? 32'(cap_wrap[i]) : 'x;
      chk($sformatf("%s_code%0d", tag, i), oc, 32'(exp_code[i]));
      chk($sformatf("%s_wrap%0d", tag, i), ow, 32'(exp_wrap[i]));
    end
  endtask

  task automatic go_idle();
    int k = 0;
    enable = 1'b0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("go_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_cfg(input string tag, input int hv, input int st, input int md);
    go_idle();
    hold_val = 8'(hv);
    step     = 8'(st);
    mode     = 2'(md);
    cap_code.delete();
    cap_wrap.delete();
    enable = 1'b1;
    wait_caps(tag, exp_code.size());
    check_seq(tag);
  endtask

  initial begin
    logic [7:0] last;
    int         k;
    int         hv, st, md;

    rst = 1'b0; enable = 1'b1; mode = 2'd1; step = 8'd3; hold_val = 8'd250;
    repeat (3) @(negedge clk);
    chk("rst_value",  32'(value),  32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_wrap",   32'(wrap),   32'd0);
    chk("rst_error",  32'(error),  32'd0);

    rst = 1'b1;
    @(negedge clk);
    chk("rel_update", 32'(update), 32'd1);
    chk("rel_busy",   32'(busy),   32'd1);
    chk("rel_value",  32'(value),  32'd250);

    exp_code = '{250, 253, 0, 3, 6};
    exp_wrap = '{0, 0, 1, 0, 0};
    wait_caps("saw_up", 5);
    check_seq("saw_up");

    exp_code = '{0, 100, 200, 255, 155, 55, 0, 100};
    exp_wrap = '{0, 0, 0, 1, 0, 0, 1, 0};
    run_cfg("tri", 0, 100, 3);

    exp_code = '{5, 251, 241};
    exp_wrap = '{0, 1, 0};
    run_cfg("saw_dn", 5, 10, 2);

    exp_code = '{7, 7, 7, 7};
    exp_wrap = '{0, 0, 0, 0};
    run_cfg("step0", 7, 0, 1);

    for (int r = 0; r < 6; r++) begin
      hv = int'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      md = int'($urandom_range(0, 3));
      model(hv, st, md, 6);
      run_cfg($sformatf("rnd%0d_m%0d", r, md), hv, st, md);
    end

    // Drop enable while a transfer is in flight.
    go_idle();
    hold_val = 8'd40; step = 8'd2; mode = 2'd1;
    cap_code.delete(); cap_wrap.delete();
    enable = 1'b1;
    wait_caps("drop", 2);
    k = 0;
    while (update && k < 50) begin @(negedge clk); k++; end
    enable = 1'b0;
    last = value;
    chk("drop_last_code", 32'(last), 32'd42);
    k = 0;
    while (!ready && k < 50) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("drop_busy_before_tick", 32'(busy), 32'd1);
    @(negedge clk);
    chk("drop_busy_after_tick", 32'(busy),   32'd0);
    chk("drop_value_held",      32'(value),  32'(last));
    chk("drop_update_low",      32'(update), 32'd0);
    repeat (20) @(negedge clk);
    chk("drop_no_new_req", 32'(cap_code.size()), 32'd2);

    // Asynchronous reset while a request is pending.
    hold_val = 8'd77; mode = 2'd0;
    enable = 1'b1;
    k = 0;
    while (!update && k < 20) begin @(negedge clk); k++; end
    #2 rst = 1'b0;
    #1;
    chk("arst_value",  32'(value),  32'd0);
    chk("arst_update", 32'(update), 32'd0);
    chk("arst_busy",   32'(busy),   32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);

    // Ready never drops.
    rsp_on = 1'b0;
    hold_val = 8'd9;
    enable = 1'b1;
    @(negedge clk);
    chk("stuck_req_up", 32'(update), 32'd1);
    repeat (1100) @(negedge clk);
`ifdef DPOT_SWEEP_TIMEOUT_EN
    chk("stuck_error",  32'(error),  32'd1);
    chk("stuck_update", 32'(update), 32'd0);
    chk("stuck_busy",   32'(busy),   32'd0);
    repeat (5) @(negedge clk);
    chk("stuck_enable_ignored", 32'(busy), 32'd0);
`else
    chk("stuck_update", 32'(update), 32'd1);
    chk("stuck_busy",   32'(busy),   32'd1);
    chk("stuck_error",  32'(error),  32'd0);
    chk("stuck_value",  32'(value),  32'd9);
`endif

    chk("no_early_update_drop", 32'(early_drop), 32'd0);
    chk("no_stray_wrap",        32'(stray_wrap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
